// File: rtl/mem_ctrl_pkg.sv
// mem_ctrl_pkg: shared state encoding and sizing constants for mem_access_ctrl.
// Contents: state_e (IDLE/ISSUE/CAPTURE/RESP), WORD_BYTES, WORD_LSB, DEF_DEPTH, DEF_CNT_W.
package mem_ctrl_pkg;
    localparam int WORD_BYTES = 4;
    localparam int WORD_LSB   = $clog2(WORD_BYTES);
    localparam int DEF_DEPTH  = 128;
    localparam int DEF_CNT_W  = 16;
    typedef enum logic [1:0] {IDLE, ISSUE, CAPTURE, RESP} state_e;
endpackage

// File: rtl/mem_align_check.sv
// mem_align_check: flags byte addresses that are misaligned or beyond the word memory.
// Ports: addr (byte address in), err (1 = misaligned or word index >= DEPTH).
module mem_align_check
    import mem_ctrl_pkg::*;
#(
    parameter int DEPTH = DEF_DEPTH
) (
    input  logic [31:0] addr,
    output logic        err
);
    assign err = (addr[WORD_LSB-1:0] != '0) || (32'(addr[31:WORD_LSB]) >= 32'(DEPTH));
endmodule

// File: rtl/mem_access_ctrl.sv
// mem_access_ctrl: single-outstanding load/store sequencer between an initiator and a word memory.
// Ports: clock_in/reset (sync, active-low); req_valid/req_ready/req_write/req_addr/req_wdata (request);
//        resp_valid/resp_ready/resp_rdata/resp_err (response); memAddress/memWriteData/memWrite/
//        memRead/memReadData (memory side); txn_count (completed non-error accesses, wrapping).
// Build option: define MEM_ALIGN_CHECK_EN to reject misaligned/out-of-range requests with resp_err.
module mem_access_ctrl
    import mem_ctrl_pkg::*;
#(
    parameter int DEPTH = DEF_DEPTH,
    parameter int CNT_W = DEF_CNT_W
) (
    input  logic             clock_in,
    input  logic             reset,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic             req_write,
    input  logic [31:0]      req_addr,
    input  logic [31:0]      req_wdata,
    output logic             resp_valid,
    input  logic             resp_ready,
    output logic [31:0]      resp_rdata,
    output logic             resp_err,
    output logic [31:0]      memAddress,
    output logic [31:0]      memWriteData,
    output logic             memWrite,
    output logic             memRead,
    input  logic [31:0]      memReadData,
    output logic [CNT_W-1:0] txn_count
);
    state_e                 state_q, state_d;
    logic                   write_q, write_d;
    logic [31-WORD_LSB:0]   addr_q, addr_d;
    logic [31:0]            wdata_q, wdata_d;
    logic [31:0]            rdata_q, rdata_d;
    logic                   err_q, err_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic                   bad;
    logic                   mem_phase;

`ifdef MEM_ALIGN_CHECK_EN
    mem_align_check #(.DEPTH(DEPTH)) u_align (
        .addr (req_addr),
        .err  (bad)
    );
`else
    // Byte offset and memory size play no part when checking is compiled out.
    logic unused_addr_lsb;
    localparam int unused_depth = DEPTH;
    assign unused_addr_lsb = ^req_addr[WORD_LSB-1:0];
    assign bad = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        write_d = write_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        err_d   = err_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: if (req_valid) begin
                write_d = req_write;
                addr_d  = req_addr[31:WORD_LSB];
                wdata_d = req_wdata;
                rdata_d = '0;
                err_d   = bad;
                state_d = bad ? RESP : ISSUE;
            end
            ISSUE:   state_d = write_q ? RESP : CAPTURE;
            CAPTURE: begin
                rdata_d = memReadData;
                state_d = RESP;
            end
            RESP: if (resp_ready) begin
                state_d = IDLE;
                cnt_d   = cnt_q + CNT_W'(!err_q);
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock_in) begin
        if (!reset) begin
            state_q <= IDLE;
            write_q <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            write_q <= write_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
            cnt_q   <= cnt_d;
        end
    end

    // Memory bus is only driven while an access is in flight; quiet otherwise.
    assign mem_phase    = (state_q == ISSUE) || (state_q == CAPTURE);
    assign req_ready    = (state_q == IDLE);
    assign resp_valid   = (state_q == RESP);
    assign resp_rdata   = resp_valid ? rdata_q : '0;
    assign resp_err     = resp_valid && err_q;
    assign memAddress   = mem_phase ? 32'(addr_q) : '0;
    assign memWriteData = mem_phase ? wdata_q : '0;
    assign memWrite     = (state_q == ISSUE) && write_q;
    assign memRead      = ((state_q == ISSUE) && !write_q) || (state_q == CAPTURE);
    assign txn_count    = cnt_q;
endmodule
